tc9_to_binary: RTL and testbench
================================

Name: tc9_to_binary

Overview:
Streaming decoder from 8-bit thermometer code to 4-bit binary for the modulo-9 residue channel. It is the inverse of the binary-to-9-TC encoder. It sits at the output of the mod-9 thermometer adder path and returns results to binary form for the reverse converter. It is a 2-stage valid/ready pipeline that validates each code, flags malformed codes, and keeps a saturating error count.

Parameters:
CNT_W, 8, width of the saturating error counter err_cnt.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous reset, active-low
in_valid  input  1  upstream word present on in_tc
in_ready  output  1  block accepts in_tc this cycle
in_tc  input  8 [8:1]  thermometer code, LSB-filled (N ones from bit 1 up)
out_valid  output  1  out_bin/out_err hold a decoded word
out_ready  input  1  downstream accepts the output word
out_bin  output  4 [4:1]  decoded residue 0..8
out_err  output  1  word was not a legal thermometer code
err_cnt  output  CNT_W  saturating count of errored words delivered
err_clr  input  1  synchronous clear of err_cnt

Behaviour:
- Reset: synchronous, active-low, sampled on the clk rising edge. While rst_n=0, all pipeline valids clear, out_valid=0, out_bin=0, out_err=0, err_cnt=0. in_ready=0 while rst_n=0. in_ready=1 in the first cycle after release. Reset mid-stream drops every in-flight word. Nothing is replayed.
- Legal codes and their decode values:
  - 00000000=0
  - 00000001=1
  - 00000011=2
  - 00000111=3
  - 00001111=4
  - 00011111=5
  - 00111111=6
  - 01111111=7
  - 11111111=8
- Any other code, e.g. 00000101 or 10000000: out_bin=0, out_err=1. A code with holes is an error even when its popcount is legal.
- Handshake: a transfer occurs when valid and ready are both 1 at a clk edge. in_valid/in_tc are sampled only on input transfer. Once out_valid=1, out_bin/out_err/out_valid stay stable until the output transfer.
- Stage 1 registers the word and its legality check, i.e. a monotonic-ones test (in_tc[k+1] -> in_tc[k] for all k). Stage 2 registers out_bin and out_err.
- Latency: 2 cycles from input transfer to out_valid=1 when not stalled. Throughput is 1 word/cycle.
- Ready chain:
  - Stage 2 may load when it is empty or when out_ready=1.
  - Stage 1 may load when it is empty or when stage 2 may load.
  - in_ready = stage-1-may-load. It is combinational from out_ready and the stage valids.
  - No combinational path from in_valid to in_ready.
- Under backpressure both stages fill: 2 words buffered and in_ready=0. No word is lost, duplicated, or reordered.
- Error counter:
  - Increments on an output transfer with out_err=1.
  - Saturates at 2^CNT_W-1 and does not wrap.
  - err_clr=1 sets it to 0 on the next edge. If err_clr coincides with an increment, clear wins (result 0).
  - err_cnt is independent of out_ready except through the transfer condition.
- in_valid=0 with in_tc=X must not propagate X into out_valid or err_cnt.

Test Plan:
- Reset, then stream codes 0x00,0x01,0x03,0x07,0x0F,0x1F,0x3F,0x7F,0xFF on consecutive cycles with out_ready=1 -> out_bin 0..8 on consecutive cycles, first out_valid 2 cycles after first accept, out_err=0 throughout, err_cnt=0.
- Send 0x05, 0x80, 0xFE, then 0x03 -> first three words: out_bin=0, out_err=1; fourth word: out_bin=2, out_err=0; err_cnt=3 after the last error transfer.
- Hold out_ready=0 for 6 cycles while offering 0x01,0x03,0x07,0x0F continuously -> exactly 2 accepted, then in_ready=0. Raising out_ready yields 1,2,3,4 in order with no gaps or duplicates.
- With CNT_W=8, deliver 260 words of 0x02 -> err_cnt stops at 255. Then assert err_clr in the same cycle as an errored transfer -> err_cnt=0.
- Pull rst_n low for 1 cycle with 2 words in flight -> out_valid=0 and err_cnt=0 on the next edge, in_ready=1 after release, and the dropped words never appear.
- Random in_valid/out_ready toggling over 1000 words against a reference model -> in-order match of out_bin/out_err, and err_cnt equals min(errors, 255).

Source files
------------

// File: rtl/tc9_to_binary.sv
`default_nettype none
// ============================================================================
// Module   : tc9_to_binary
// Purpose  : Two-stage valid/ready decoder from 8-bit mod-9 thermometer code
//            to 4-bit binary, flagging malformed codes with a saturating count.
// Revision : 1.0 - initial release
// ============================================================================
module tc9_to_binary #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [8:1]       in_tc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:1]       out_bin,
    output logic             out_err,
    output logic [CNT_W-1:0] err_cnt,
    input  logic             err_clr
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;
    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             r_s1_valid;
    logic [8:1]       r_s1_tc;
    logic             r_s1_legal;
    logic             r_s2_valid;
    logic [4:1]       r_s2_bin;
    logic             r_s2_err;
    logic [CNT_W-1:0] r_err_cnt;

    logic             w_s2_ld;
    logic             w_s1_ld;
    logic             w_legal;
    logic             w_out_xfer;
    logic [4:1]       w_ones;

    // Each stage may advance when it is empty or its successor will advance.
    assign w_s2_ld    = !r_s2_valid || out_ready;
    assign w_s1_ld    = !r_s1_valid || w_s2_ld;
    assign in_ready   = rst_n && w_s1_ld;
    assign w_out_xfer = r_s2_valid && out_ready;

    // Legal iff the ones are contiguous from bit 1: no set bit above a clear one.
    always_comb begin
        w_legal = 1'b1;
        for (int k = 1; k < 8; k++) begin
            if (in_tc[k+1] && !in_tc[k]) begin
                w_legal = 1'b0;
            end
        end
    end

    always_comb begin
        w_ones = '0;
        for (int k = 1; k <= 8; k++) begin
            w_ones = w_ones + {3'b000, r_s1_tc[k]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_tc    <= '0;
            r_s1_legal <= 1'b0;
        end else if (w_s1_ld) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_tc    <= in_tc;
                r_s1_legal <= w_legal;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_bin   <= '0;
            r_s2_err   <= 1'b0;
        end else if (w_s2_ld) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_bin <= r_s1_legal ? w_ones : 4'd0;
                r_s2_err <= !r_s1_legal;
            end
        end
    end

    // Clear has priority over a coincident increment.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (err_clr) begin
            r_err_cnt <= '0;
        end else if (w_out_xfer && r_s2_err && (r_err_cnt != c_cnt_max)) begin
            r_err_cnt <= r_err_cnt + c_cnt_one;
        end
    end

    assign out_valid = r_s2_valid;
    assign out_bin   = r_s2_bin;
    assign out_err   = r_s2_err;
    assign err_cnt   = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_tc9_to_binary.sv
`default_nettype none
// ============================================================================
// Module   : tb_tc9_to_binary
// Purpose  : Self-checking bench for tc9_to_binary against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tc9_to_binary;

    localparam int CNT_W = 8;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             in_valid  = 1'b0;
    logic [7:0]       in_tc     = 8'h00;
    logic             out_ready = 1'b0;
    logic             err_clr   = 1'b0;
    logic             in_ready;
    logic             out_valid;
    logic [3:0]       out_bin;
    logic             out_err;
    logic [CNT_W-1:0] err_cnt;

    tc9_to_binary #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_tc     (in_tc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bin   (out_bin),
        .out_err   (out_err),
        .err_cnt   (err_cnt),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: a legal code is 2^n-1 for n in 0..8; returns n, or 16 for an error.
    function automatic int ref_decode(input logic [7:0] tc);
        for (int n = 0; n <= 8; n++) begin
            if ({1'b0, tc} == 9'((1 << n) - 1)) return n;
        end
        return 16;
    endfunction

    int  exp_q[$];
    int  acc_q[$];
    int  obs_q[$];
    int  model_cnt = 0;
    int  cyc       = 0;
    bit  lat_chk   = 1'b0;
    bit  prev_rst  = 1'b0;
    bit  prev_hold = 1'b0;
    logic [3:0] prev_bin = 4'd0;
    logic       prev_err = 1'b0;

    always @(negedge clk) begin
        int e, c, eb, ee;
        cyc++;
        if (prev_rst) begin
            check("rst_out_valid", out_valid, 0);
            check("rst_out_bin", out_bin, 0);
            check("rst_out_err", out_err, 0);
            check("rst_err_cnt", err_cnt, 0);
        end
        if (!rst_n) begin
            check("in_ready_in_reset", in_ready, 0);
            exp_q.delete();
            acc_q.delete();
            model_cnt = 0;
            prev_rst  = 1'b1;
            prev_hold = 1'b0;
        end else begin
            if (prev_rst) check("in_ready_after_rst", in_ready, 1);
            prev_rst = 1'b0;
            check("err_cnt", err_cnt, model_cnt);
            if (prev_hold) begin
                check("hold_valid", out_valid, 1);
                check("hold_bin", out_bin, prev_bin);
                check("hold_err", out_err, prev_err);
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_decode(in_tc));
                acc_q.push_back(cyc);
            end
            ee = 0;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    e  = exp_q.pop_front();
                    c  = acc_q.pop_front();
                    eb = (e == 16) ? 0 : e;
                    ee = (e == 16) ? 1 : 0;
                    check("out_bin", out_bin, eb);
                    check("out_err", out_err, ee);
                    if (lat_chk) check("latency", cyc - c, 2);
                    obs_q.push_back(ee * 16 + int'(out_bin));
                end
            end
            if (err_clr) model_cnt = 0;
            else if (ee == 1 && model_cnt < MAXC) model_cnt++;
            prev_hold = out_valid && !out_ready;
            prev_bin  = out_bin;
            prev_err  = out_err;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] tc);
        int n = 0;
        in_valid = 1'b1;
        in_tc    = tc;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("send_timeout", 1, 0);
        tick();
        in_valid = 1'b0;
        in_tc    = 8'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        @(negedge clk);
        #1;
        while ((exp_q.size() != 0 || out_valid) && n < 500) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 500) check("drain_timeout", 1, 0);
        tick();
    endtask

    logic [7:0] legal_codes [9] = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F,
                                    8'h1F, 8'h3F, 8'h7F, 8'hFF};
    logic [7:0] p2_codes [4] = '{8'h05, 8'h80, 8'hFE, 8'h03};
    int         p2_exp   [4] = '{16, 16, 16, 2};
    logic [7:0] p3_codes [4] = '{8'h01, 8'h03, 8'h07, 8'h0F};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, idx, acc, n, ph_err;
        bit done, accepted;
        logic [8:0] w;
        logic [7:0] tc;

        check("model_00", ref_decode(8'h00), 0);
        check("model_7f", ref_decode(8'h7F), 7);
        check("model_ff", ref_decode(8'hFF), 8);
        check("model_05", ref_decode(8'h05), 16);
        check("model_80", ref_decode(8'h80), 16);

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Legal sweep, back-to-back with no backpressure.
        out_ready = 1'b1;
        lat_chk   = 1'b1;
        base      = obs_q.size();
        foreach (legal_codes[i]) send(legal_codes[i]);
        drain();
        lat_chk = 1'b0;
        for (int i = 0; i < 9; i++) check("sweep_seq", obs_q[base + i], i);
        check("sweep_err_cnt", err_cnt, 0);

        // Malformed codes including a hole with legal popcount.
        base = obs_q.size();
        foreach (p2_codes[i]) send(p2_codes[i]);
        drain();
        for (int i = 0; i < 4; i++) check("bad_seq", obs_q[base + i], p2_exp[i]);
        @(negedge clk);
        check("bad_err_cnt", err_cnt, 3);
        tick();

        // Backpressure: two words buffered, then in_ready drops.
        out_ready = 1'b0;
        base = obs_q.size();
        idx  = 0;
        acc  = 0;
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1;
            in_tc    = p3_codes[idx];
            @(negedge clk);
            accepted = in_ready;
            tick();
            if (accepted) begin
                acc++;
                idx++;
            end
        end
        check("bp_accepted", acc, 2);
        @(negedge clk);
        check("bp_in_ready", in_ready, 0);
        tick();
        out_ready = 1'b1;
        for (int i = idx; i < 4; i++) send(p3_codes[i]);
        drain();
        for (int i = 0; i < 4; i++) check("bp_seq", obs_q[base + i], i + 1);

        // Saturation, then clear coinciding with an errored transfer.
        repeat (260) send(8'h02);
        drain();
        @(negedge clk);
        check("sat_err_cnt", err_cnt, MAXC);
        tick();
        out_ready = 1'b0;
        send(8'h02);
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("clr_wait_valid", out_valid, 1);
        tick();
        err_clr   = 1'b1;
        out_ready = 1'b1;
        tick();
        err_clr = 1'b0;
        @(negedge clk);
        check("clr_wins", err_cnt, 0);
        tick();

        // Reset with two words in flight.
        send(8'h80);
        drain();
        @(negedge clk);
        check("pre_rst_err_cnt", err_cnt, 1);
        tick();
        out_ready = 1'b0;
        send(8'h01);
        send(8'h03);
        base  = obs_q.size();
        rst_n = 1'b0;
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("post_rst_valid", out_valid, 0);
        check("post_rst_err_cnt", err_cnt, 0);
        check("post_rst_in_ready", in_ready, 1);
        repeat (6) tick();
        @(negedge clk);
        #1;
        check("dropped_words", obs_q.size(), base);
        tick();

        // Random traffic against the model.
        ph_err = 0;
        done   = 1'b0;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    repeat ($urandom_range(0, 2)) tick();
                    if ($urandom_range(0, 1) == 1) tc = legal_codes[$urandom_range(0, 8)];
                    else tc = 8'($urandom);
                    w = {1'b0, tc};
                    if (((w + 9'd1) & w) != 9'd0) ph_err++;
                    send(tc);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    out_ready = ($urandom_range(0, 2) != 0);
                    tick();
                end
            end
        join
        out_ready = 1'b1;
        drain();
        @(negedge clk);
        check("rand_err_cnt", err_cnt, (ph_err > MAXC) ? MAXC : ph_err);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
